// File: rtl/keypad_event_gen_if.sv
// Event interface between a raw keypad and the phone controller front end.
// master = keypad side (drives level/code), slave = keypad_event_gen (drives events).
interface keypad_event_gen_if;
  logic       keyDown;
  logic [3:0] keyCode;
  logic       Keypressed;
  logic       Keyreleased;
  logic [3:0] charSent;

  modport master (
    output keyDown,
    output keyCode,
    input  Keypressed,
    input  Keyreleased,
    input  charSent
  );

  modport slave (
    input  keyDown,
    input  keyCode,
    output Keypressed,
    output Keyreleased,
    output charSent
  );
endinterface

// File: rtl/keypad_event_gen.sv
// Keypad front end: 2-flop synchroniser, debounce FSM, registered press/release pulses.
// Define KEY_REPEAT_EN to add the auto-repeat generator while a key is held.
module keypad_event_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned REPEAT_DELAY    = 32,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic               clk,
  input  logic               rst,
  keypad_event_gen_if.slave  kif
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchroniser stages
  logic       r_down_meta;
  logic       r_down_sync;
  logic [3:0] r_code_meta;
  logic [3:0] r_code_sync;

  // FSM state and datapath registers
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_cand_code;
  logic [3:0]       r_char_sent;
  logic             r_keypressed;
  logic             r_keyreleased;

  // Next-state values
  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [3:0]       w_cand_next;
  logic [3:0]       w_char_next;
  logic             w_press_next;
  logic             w_release_next;
  logic             w_enter_held;
  logic             w_press_any;

  logic             w_s_down;
  logic [3:0]       w_s_code;

  assign w_s_down = r_down_sync;
  assign w_s_code = r_code_sync;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_down_meta <= 1'b0;
      r_down_sync <= 1'b0;
      r_code_meta <= 4'h0;
      r_code_sync <= 4'h0;
    end else begin
      r_down_meta <= kif.keyDown;
      r_down_sync <= r_down_meta;
      r_code_meta <= kif.keyCode;
      r_code_sync <= r_code_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_cand_code   <= 4'h0;
      r_char_sent   <= 4'h0;
      r_keypressed  <= 1'b0;
      r_keyreleased <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_cand_code   <= w_cand_next;
      r_char_sent   <= w_char_next;
      r_keypressed  <= w_press_any;
      r_keyreleased <= w_release_next;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_cand_next    = r_cand_code;
    w_char_next    = r_char_sent;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_enter_held   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_s_down) begin
          w_state_next = PRESS_DB;
          w_cand_next  = w_s_code;
          w_cnt_next   = '0;
        end
      end

      PRESS_DB: begin
        if (!w_s_down) begin
          w_state_next = IDLE;
        end else if (w_s_code != r_cand_code) begin
          w_cand_next = w_s_code;
          w_cnt_next  = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_next = HELD;
          w_char_next  = r_cand_code;
          w_press_next = 1'b1;
          w_enter_held = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      // Code changes while held are ignored: the first accepted key owns the hold.
      HELD: begin
        if (!w_s_down) begin
          w_state_next = RELEASE_DB;
          w_cnt_next   = '0;
        end
      end

      RELEASE_DB: begin
        if (w_s_down) begin
          w_state_next = HELD;
          w_enter_held = 1'b1;
        end else if (r_cnt == DB_LAST) begin
          w_state_next   = IDLE;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CNT_W-1:0] r_rcnt;
  logic [CNT_W-1:0] w_rcnt_next;
  logic             w_repeat;

  // After the first repeat the counter reloads so the next hit lands REPEAT_PERIOD later.
  always_comb begin
    w_rcnt_next = r_rcnt;
    w_repeat    = 1'b0;
    if (w_enter_held) begin
      w_rcnt_next = '0;
    end else if ((r_state == HELD) && w_s_down) begin
      if (r_rcnt == RPT_LAST) begin
        w_repeat    = 1'b1;
        w_rcnt_next = RPT_RELOAD;
      end else begin
        w_rcnt_next = r_rcnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt <= '0;
    end else begin
      r_rcnt <= w_rcnt_next;
    end
  end

  assign w_press_any = w_press_next | w_repeat;
`else
  assign w_press_any = w_press_next;
`endif

  assign kif.Keypressed  = r_keypressed;
  assign kif.Keyreleased = r_keyreleased;
  assign kif.charSent    = r_char_sent;

endmodule

// File: doc/keypad_event_gen.md
Name: keypad_event_gen

Overview:
- Front-end stage that sits directly upstream of the phone controller.
- Converts a raw, bouncy keypad level (keyDown) and its 4-bit key code (keyCode) into the controller's event interface: single-cycle Keypressed and Keyreleased pulses, plus a held charSent code.
- Contains a 2-flop input synchroniser, a debounce FSM and, optionally, an auto-repeat generator.

Parameters:
- DEBOUNCE_CYCLES, 4: cycles the synchronised input must stay stable before a press or release is accepted; legal range is 1 to 2^CNT_W-1.
- CNT_W, 16: width of the debounce and repeat counters.
- REPEAT_DELAY, 32: cycles from the initial Keypressed pulse to the first repeat pulse (KEY_REPEAT_EN only).
- REPEAT_PERIOD, 8: cycles between subsequent repeat pulses (KEY_REPEAT_EN only).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- keyDown  input  1  raw key-active level, asynchronous to clk.
- keyCode  input  4  raw key code, asynchronous to clk; meaningful only while keyDown=1.
- Keypressed  output  1  one-cycle pulse marking an accepted press (or a repeat).
- Keyreleased  output  1  one-cycle pulse marking an accepted release.
- charSent  output  4  code of the last accepted press; valid in the same cycle as Keypressed.

Behaviour:
- Reset (synchronous): sync flops=0, state=IDLE, counters=0, candCode=0, Keypressed=0, Keyreleased=0, charSent=4'h0.
  - Reset mid-operation aborts any press or hold; no Keyreleased is emitted.
- Synchroniser: keyDown and keyCode each pass through 2 flops, giving s_down and s_code. The FSM sees only s_down/s_code.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. All outputs are registered.
- IDLE:
  - s_down=1 -> PRESS_DB; candCode<=s_code; cnt<=0.
- PRESS_DB:
  - s_down=0 -> IDLE; glitch, no output.
  - s_code!=candCode -> stay; candCode<=s_code; cnt<=0 (debounce restarts).
  - cnt==DEBOUNCE_CYCLES-1 with input stable -> HELD; charSent<=candCode; Keypressed<=1 for one cycle.
  - Otherwise cnt++.
- HELD:
  - s_down=0 -> RELEASE_DB; cnt<=0.
  - s_code changes are ignored; the first accepted key owns the hold.
- RELEASE_DB:
  - s_down=1 -> HELD; bounce, no pulse, no new Keypressed.
  - cnt==DEBOUNCE_CYCLES-1 -> IDLE; Keyreleased<=1 for one cycle; charSent unchanged.
  - Otherwise cnt++.
- Latency: with edges numbered from 1 as the first edge sampling the new input level, Keypressed (press) and Keyreleased (release) are high after edge DEBOUNCE_CYCLES+3. For D=4 that is edge 7.
- Invariants:
  - Keypressed and Keyreleased are never high in the same cycle.
  - Every Keyreleased is preceded by exactly one non-repeat Keypressed.
  - charSent changes only in a cycle where Keypressed asserts, and holds otherwise, including through release and IDLE.
- Counter saturation is not needed: cnt never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - A repeat counter rcnt clears on every entry to HELD and increments each cycle while in HELD.
  - With the initial Keypressed in cycle c, further Keypressed pulses (same charSent) occur at c+REPEAT_DELAY, then every REPEAT_PERIOD cycles, while the FSM remains in HELD.
  - RELEASE_DB freezes rcnt. A bounce back to HELD clears rcnt, so the repeat schedule restarts from that HELD entry.
- Undefined: exactly one Keypressed per accepted press; no repeat logic is synthesised.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert rst 2 cycles with keyDown=1 -> Keypressed=0, Keyreleased=0, charSent=0, no pulse during reset.
- Clean press: keyCode=5, keyDown=1 for 20 cycles, then 0 ->
  - exactly one Keypressed, after edge 7, with charSent=5;
  - exactly one Keyreleased, after edge 7 following the fall;
  - charSent stays 5 afterwards.
- Glitch rejection: keyDown=1 for 3 cycles then 0 -> no Keypressed, no Keyreleased, charSent unchanged.
- Code change during debounce: keyCode=3 then 7 on cycle 2 of the press -> one Keypressed with charSent=7, after edge 7 counted from the code change.
- Release bounce: while HELD, keyDown=0 for 2 cycles then 1 for 10, then 0 -> no extra Keypressed; one Keyreleased only after the final stable release.
- Repeat (KEY_REPEAT_EN) and mid-hold reset:
  - hold keyCode=9 for 100 cycles -> Keypressed at c, c+32, c+40, c+48, …, all with charSent=9;
  - rst asserted mid-hold -> outputs 0 next cycle, no Keyreleased.
